nes_palette_writer: RTL and testbench

Writer side of the NES palette memory: a 32-entry × 6-bit palette RAM loaded through a PPU-style register port (ADDR/DATA/CTRL/STATUS) with the two-write address latch, auto-increment and NES palette mirroring. It holds the same 32 entries that the fixed palette ROMs hold, but as state that the CPU/loader writes at run time. The renderer reads it through an independent registered read port.

---
 rtl/nes_palette_writer.sv | 130 +++++++++++++
 tb/tb_nes_palette_writer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/nes_palette_writer.sv
// NES palette RAM (32 x 6) loaded through a PPU-style ADDR/DATA/CTRL/STATUS register port,
// with a two-write address latch, auto-increment, palette mirroring and a registered renderer read port.
module nes_palette_writer #(
    parameter logic [5:0] RST_COLOR = 6'h0F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [1:0]  cpu_reg,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_rvalid,
    output logic [13:0] vaddr,
    input  logic        render_en,
    output logic        wr_drop,
    input  logic [4:0]  rend_addr,
    output logic [5:0]  rend_dout
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_ADDR   = 2'd2;
    localparam logic [1:0] REG_DATA   = 2'd3;

    logic [13:0] vaddr_q, vaddr_d;
    logic [5:0]  t_hi_q, t_hi_d;
    logic        toggle_q, toggle_d;
    logic        inc32_q, inc32_d;
    logic [5:0]  pal_q [32];
    logic [5:0]  pal_d [32];
    logic [7:0]  cpu_dout_q, cpu_dout_d;
    logic        cpu_rvalid_q, cpu_rvalid_d;
    logic        wr_drop_q, wr_drop_d;
    logic [5:0]  rend_dout_q, rend_dout_d;

    logic        in_pal;
    logic [4:0]  cpu_idx;
    logic [13:0] vaddr_inc;

    // Entries 0x10/0x14/0x18/0x1C share storage with 0x00/0x04/0x08/0x0C.
    function automatic logic [4:0] pal_idx(input logic [4:0] a);
        pal_idx = (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
    endfunction

    assign in_pal    = (vaddr_q[13:8] == 6'h3F);
    assign cpu_idx   = pal_idx(vaddr_q[4:0]);
    assign vaddr_inc = vaddr_q + (inc32_q ? 14'd32 : 14'd1);

    always_comb begin
        vaddr_d      = vaddr_q;
        t_hi_d       = t_hi_q;
        toggle_d     = toggle_q;
        inc32_d      = inc32_q;
        pal_d        = pal_q;
        cpu_dout_d   = cpu_dout_q;
        cpu_rvalid_d = 1'b0;
        wr_drop_d    = 1'b0;
        // Renderer sees the pre-write contents when it collides with a CPU write.
        rend_dout_d  = pal_q[pal_idx(rend_addr)];

        if (cpu_we) begin
            case (cpu_reg)
                REG_CTRL: inc32_d = cpu_din[2];
                REG_ADDR: begin
                    if (!toggle_q) begin
                        t_hi_d   = cpu_din[5:0];
                        toggle_d = 1'b1;
                    end else begin
                        vaddr_d  = {t_hi_q, cpu_din};
                        toggle_d = 1'b0;
                    end
                end
                REG_DATA: begin
                    if (render_en) begin
                        wr_drop_d = 1'b1;
                    end else begin
                        if (in_pal) pal_d[cpu_idx] = cpu_din[5:0];
                        vaddr_d = vaddr_inc;
                    end
                end
                default: ;
            endcase
        end else if (cpu_re) begin
            cpu_rvalid_d = 1'b1;
            case (cpu_reg)
                REG_STATUS: begin
                    cpu_dout_d = {render_en, 7'b0};
                    toggle_d   = 1'b0;
                end
                REG_DATA: begin
                    cpu_dout_d = in_pal ? {2'b00, pal_q[cpu_idx]} : 8'h00;
                    vaddr_d    = vaddr_inc;
                end
                default: cpu_dout_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vaddr_q      <= '0;
            t_hi_q       <= '0;
            toggle_q     <= 1'b0;
            inc32_q      <= 1'b0;
            for (int i = 0; i < 32; i++) pal_q[i] <= RST_COLOR;
            cpu_dout_q   <= '0;
            cpu_rvalid_q <= 1'b0;
            wr_drop_q    <= 1'b0;
            rend_dout_q  <= RST_COLOR;
        end else begin
            vaddr_q      <= vaddr_d;
            t_hi_q       <= t_hi_d;
            toggle_q     <= toggle_d;
            inc32_q      <= inc32_d;
            pal_q        <= pal_d;
            cpu_dout_q   <= cpu_dout_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            wr_drop_q    <= wr_drop_d;
            rend_dout_q  <= rend_dout_d;
        end
    end

    assign vaddr      = vaddr_q;
    assign cpu_dout   = cpu_dout_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign wr_drop    = wr_drop_q;
    assign rend_dout  = rend_dout_q;

endmodule

// File: tb/tb_nes_palette_writer.sv
// Scoreboard bench for nes_palette_writer: directed register sequences plus random traffic,
// checked against an array/arithmetic model of the palette register port.
module tb_nes_palette_writer;

    localparam logic [5:0] RST_C = 6'h0F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_we = 1'b0, cpu_re = 1'b0;
    logic [1:0]  cpu_reg = 2'd0;
    logic [7:0]  cpu_din = 8'd0;
    logic [7:0]  cpu_dout;
    logic        cpu_rvalid;
    logic [13:0] vaddr;
    logic        render_en = 1'b0;
    logic        wr_drop;
    logic [4:0]  rend_addr = 5'd0;
    logic [5:0]  rend_dout;

    nes_palette_writer #(.RST_COLOR(RST_C)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_reg(cpu_reg), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .cpu_rvalid(cpu_rvalid), .vaddr(vaddr), .render_en(render_en),
        .wr_drop(wr_drop), .rend_addr(rend_addr), .rend_dout(rend_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rend;
        int vaddr;
        int drop;
        int rvalid;
    } cyc_exp_t;

    cyc_exp_t cyc_q[$];
    int       dout_q[$];
    int       n_checks = 0;
    int       n_fail = 0;
    bit       mon_en = 1'b0;

    // Reference model state
    int m_pal[32];
    int m_vaddr, m_thi, m_toggle, m_inc32;
    bit g_ren = 1'b0;
    int g_ra = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pmap(input int a);
        int idx;
        idx = a % 32;
        if (idx >= 16 && idx % 4 == 0) idx = idx - 16;
        return idx;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_pal[i] = RST_C;
        m_vaddr = 0; m_thi = 0; m_toggle = 0; m_inc32 = 0;
    endfunction

    function automatic void model_advance();
        m_vaddr = (m_vaddr + (m_inc32 != 0 ? 32 : 1)) % 16384;
    endfunction

    task automatic cycle(input bit we, input bit re, input int rg, input int din,
                         input bit ren, input int ra);
        cyc_exp_t e;
        bit in_pal;
        @(negedge clk);
        cpu_we = we; cpu_re = re; cpu_reg = rg[1:0]; cpu_din = din[7:0];
        render_en = ren; rend_addr = ra[4:0];
        in_pal = (m_vaddr / 256) == 63;
        e.rend   = m_pal[pmap(ra)];
        e.rvalid = (re && !we) ? 1 : 0;
        e.drop   = (we && rg == 3 && ren) ? 1 : 0;
        if (we) begin
            case (rg)
                0: m_inc32 = (din / 4) % 2;
                2: if (m_toggle == 0) begin
                       m_thi = din % 64; m_toggle = 1;
                   end else begin
                       m_vaddr = m_thi * 256 + din; m_toggle = 0;
                   end
                3: if (!ren) begin
                       if (in_pal) m_pal[pmap(m_vaddr)] = din % 64;
                       model_advance();
                   end
                default: ;
            endcase
        end else if (re) begin
            case (rg)
                1: begin dout_q.push_back(ren ? 128 : 0); m_toggle = 0; end
                3: begin dout_q.push_back(in_pal ? m_pal[pmap(m_vaddr)] : 0); model_advance(); end
                default: dout_q.push_back(0);
            endcase
        end
        e.vaddr = m_vaddr;
        cyc_q.push_back(e);
        mon_en = 1'b1;
        @(posedge clk);
    endtask

    task automatic wr(input int rg, input int din); cycle(1, 0, rg, din, g_ren, g_ra); endtask
    task automatic rd(input int rg); cycle(0, 1, rg, 0, g_ren, g_ra); endtask
    task automatic idle(); cycle(0, 0, 0, 0, g_ren, g_ra); endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en = 1'b0;
        cpu_we = 1'b0; cpu_re = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("rst_vaddr", vaddr, 0);
        chk("rst_cpu_dout", cpu_dout, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_wr_drop", wr_drop, 0);
        chk("rst_rend_dout", rend_dout, RST_C);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops the per-cycle expectation and, when a read result is presented, the read queue.
    always @(posedge clk) begin
        cyc_exp_t e;
        int d;
        #1;
        if (mon_en && rst_n) begin
            if (cyc_q.size() == 0) begin
                chk("cyc_queue_underflow", 1, 0);
            end else begin
                e = cyc_q.pop_front();
                chk("rend_dout", rend_dout, e.rend);
                chk("vaddr", vaddr, e.vaddr);
                chk("wr_drop", wr_drop, e.drop);
                chk("cpu_rvalid", cpu_rvalid, e.rvalid);
            end
            if (cpu_rvalid) begin
                if (dout_q.size() == 0) begin
                    chk("unexpected_rvalid", 1, 0);
                end else begin
                    d = dout_q.pop_front();
                    chk("cpu_dout", cpu_dout, d);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();

        // Reset mid-operation, including half-finished ADDR sequence
        wr(2, 8'h3F); wr(2, 8'h00); wr(3, 8'h12); wr(2, 8'h3F);
        do_reset();
        for (int i = 0; i < 32; i++) begin g_ra = i; idle(); end
        idle();

        // Address latch and load
        wr(2, 8'h3F); wr(2, 8'h00);
        wr(3, 8'h15); wr(3, 8'h2D); wr(3, 8'h27); wr(3, 8'h30);
        for (int i = 0; i < 4; i++) begin g_ra = i; idle(); end
        g_ra = 4; idle();
        wr(3, 8'hFF); idle(); idle();

        // Mirroring
        wr(2, 8'h3F); wr(2, 8'h10); wr(3, 8'h21);
        g_ra = 0; idle(); g_ra = 16; idle();
        wr(2, 8'h3F); wr(2, 8'h11); wr(3, 8'h1C);
        g_ra = 1; idle(); g_ra = 17; idle();

        // Increment by 32 and 14-bit wrap
        wr(0, 8'h04); wr(2, 8'h3F); wr(2, 8'hF0); rd(3); idle();
        wr(0, 8'h00); wr(2, 8'h3F); wr(2, 8'hFF); wr(3, 8'h00); idle();

        // Toggle restart by STATUS read, STATUS with render_en
        wr(2, 8'h3F); rd(1); wr(2, 8'h3F); wr(2, 8'h05); idle();
        g_ren = 1; rd(1); g_ren = 0; idle();

        // Read outside palette range, ignored register reads
        wr(2, 8'h20); wr(2, 8'h00); rd(3); rd(0); rd(2);

        // Render block, read-before-write collision, simultaneous strobes
        wr(2, 8'h3F); wr(2, 8'h02);
        g_ren = 1; wr(3, 8'h11); rd(3); g_ren = 0;
        wr(2, 8'h3F); wr(2, 8'h02);
        g_ra = 2; wr(3, 8'h2A); idle(); idle();
        cycle(1, 1, 3, 8'h05, 1'b0, 2); idle();
        cycle(1, 1, 1, 8'h00, 1'b0, 2); rd(3); idle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int r, rg, din;
            r  = $urandom_range(0, 9);
            rg = $urandom_range(0, 3);
            din = $urandom_range(0, 255);
            if (rg == 2 && m_toggle == 0 && $urandom_range(0, 3) != 0) din = 8'h3F;
            if (rg == 2 && m_toggle == 1) din = $urandom_range(0, 1) ? (din % 32) : din;
            g_ren = ($urandom_range(0, 5) == 0);
            g_ra  = $urandom_range(0, 31);
            if (r < 4)       cycle(1, 0, rg, din, g_ren, g_ra);
            else if (r < 8)  cycle(0, 1, rg, din, g_ren, g_ra);
            else if (r < 9)  cycle(1, 1, rg, din, g_ren, g_ra);
            else             cycle(0, 0, rg, din, g_ren, g_ra);
        end
        g_ren = 0;
        for (int i = 0; i < 32; i++) begin g_ra = i; idle(); end

        @(negedge clk);
        mon_en = 1'b0;
        cpu_we = 1'b0; cpu_re = 1'b0;
        chk("dout_queue_leftover", dout_q.size(), 0);
        chk("cyc_queue_leftover", cyc_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
